// File: rtl/hazard_tracker_pkg.sv
// Shared types for the forwarding/hazard tracker: select encodings and
// the in-flight destination tag carried down the tracking pipe.
package hazard_pkg;

    // Widest register address a tag can carry; REG_AW must not exceed it.
    localparam int MAX_AW = 8;

    // Select value meaning "read the register file".
    localparam int FWD_RF = 0;

    // Select value for a producer sitting in tracked stage p.
    function automatic int FWD_STAGE(input int p);
        return p + 1;
    endfunction

    typedef struct packed {
        logic              valid;
        logic [MAX_AW-1:0] rd;
        logic              wr;
        logic              load;
    } tag_t;

endpackage

// File: rtl/hazard_tracker_if.sv
// ID-stage request bundle and hazard/forward responses.
// master: pipeline controller (drives ID info, hold, flush).
// slave: hazard_tracker (drives stall, selects, stall counter).
interface hazard_tracker_if #(
    parameter int REG_AW = 4,
    parameter int SEL_W  = 2,
    parameter int CNT_W  = 16
);
    logic              id_valid;
    logic [REG_AW-1:0] id_rd;
    logic              id_rw;
    logic              id_load;
    logic [REG_AW-1:0] id_rs;
    logic [REG_AW-1:0] id_rt;
    logic              id_use_rs;
    logic              id_use_rt;
    logic              id_jr;
    logic              hold;
    logic              flush;
    logic              stall;
    logic [SEL_W-1:0]  fwd_a;
    logic [SEL_W-1:0]  fwd_b;
    logic [SEL_W-1:0]  jr_sel;
    logic [CNT_W-1:0]  stall_count;

    modport master (
        output id_valid, id_rd, id_rw, id_load,
        output id_rs, id_rt, id_use_rs, id_use_rt,
        output id_jr, hold, flush,
        input  stall, fwd_a, fwd_b, jr_sel, stall_count
    );

    modport slave (
        input  id_valid, id_rd, id_rw, id_load,
        input  id_rs, id_rt, id_use_rs, id_use_rt,
        input  id_jr, hold, flush,
        output stall, fwd_a, fwd_b, jr_sel, stall_count
    );
endinterface

// File: rtl/hazard_tracker_fwd_match.sv
// Priority matcher: youngest forwardable stage writing register r.
// Ports: pipe (forwardable tags, [0] = EX), r, sel (0 = regfile), hit.
module fwd_match
    import hazard_pkg::*;
#(
    parameter int REG_AW = 4,
    parameter int NP     = 2,
    parameter int SEL_W  = 2
) (
    input  tag_t [NP-1:0]     pipe,
    input  logic [REG_AW-1:0] r,
    output logic [SEL_W-1:0]  sel,
    output logic              hit
);

    always_comb begin
        sel = SEL_W'(FWD_RF);
        hit = 1'b0;
        // Walk oldest to youngest so the youngest match is written last.
        for (int p = NP - 1; p >= 0; p--) begin
            if (pipe[p].valid && pipe[p].wr &&
                pipe[p].rd == MAX_AW'(r) && r != '0) begin
                sel = SEL_W'(FWD_STAGE(p));
                hit = 1'b1;
            end
        end
    end

endmodule

// File: rtl/hazard_tracker.sv
// Forwarding and load-use/JR hazard unit with registered EX selects.
// Ports: clk, rst_n (sync, active low), hz (slave side of the bundle).
module hazard_tracker
    import hazard_pkg::*;
#(
    parameter int REG_AW = 4,
    parameter int DEPTH  = 3,
    parameter int SEL_W  = $clog2(DEPTH),
    parameter int CNT_W  = 16
) (
    input logic           clk,
    input logic           rst_n,
    hazard_tracker_if.slave hz
);

    // The last tracked stage retires through the register file and is
    // never forwarded from, so only the first DEPTH-1 tags are stored.
    localparam int NP = DEPTH - 1;
    localparam logic [SEL_W-1:0] SEL_EX = SEL_W'(FWD_STAGE(0));

    tag_t [NP-1:0]    pipe;
    tag_t             id_tag;
    logic [SEL_W-1:0] sel_a;
    logic [SEL_W-1:0] sel_b;
    logic [SEL_W-1:0] sel_j;
    logic             hit_a;
    logic             hit_b;
    logic             hit_j;
    logic             ex_load;
    logic             lu_a;
    logic             lu_b;
    logic             jr_haz;
    logic             issue;

    fwd_match #(.REG_AW(REG_AW), .NP(NP), .SEL_W(SEL_W)) u_rs (
        .pipe (pipe),
        .r    (hz.id_rs),
        .sel  (sel_a),
        .hit  (hit_a)
    );

    fwd_match #(.REG_AW(REG_AW), .NP(NP), .SEL_W(SEL_W)) u_rt (
        .pipe (pipe),
        .r    (hz.id_rt),
        .sel  (sel_b),
        .hit  (hit_b)
    );

    fwd_match #(.REG_AW(REG_AW), .NP(NP), .SEL_W(SEL_W)) u_jr (
        .pipe (pipe),
        .r    (hz.id_rs),
        .sel  (sel_j),
        .hit  (hit_j)
    );

    // A select of SEL_EX means the youngest producer is the EX-stage one.
    assign ex_load = pipe[0].load;
    assign lu_a    = hit_a && sel_a == SEL_EX && ex_load && hz.id_use_rs;
    assign lu_b    = hit_b && sel_b == SEL_EX && ex_load && hz.id_use_rt;
    assign jr_haz  = hz.id_jr && hit_j && sel_j == SEL_EX && ex_load;

    assign hz.stall  = hz.id_valid && !hz.flush && (lu_a || lu_b || jr_haz);
    assign hz.jr_sel = hz.id_jr ? sel_j : SEL_W'(FWD_RF);

    assign issue = hz.id_valid && !hz.stall && !hz.flush && !hz.hold;

    always_comb begin
        id_tag       = '0;
        id_tag.valid = 1'b1;
        id_tag.rd    = MAX_AW'(hz.id_rd);
        id_tag.wr    = hz.id_rw && hz.id_rd != '0;
        id_tag.load  = hz.id_load;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pipe           <= '0;
            hz.fwd_a       <= '0;
            hz.fwd_b       <= '0;
            hz.stall_count <= '0;
        end else if (!hz.hold) begin
            pipe[0] <= issue ? id_tag : '0;
            for (int k = 1; k < NP; k++) begin
                pipe[k] <= pipe[k-1];
            end
            hz.fwd_a <= issue ? sel_a : SEL_W'(FWD_RF);
            hz.fwd_b <= issue ? sel_b : SEL_W'(FWD_RF);
            if (hz.stall && hz.stall_count != '1) begin
                hz.stall_count <= hz.stall_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hazard_tracker.sv
// Directed bench for hazard_tracker: history-queue model checked every
// cycle, plus literal expectations for each scenario.
module tb_hazard_tracker;

    localparam int DEPTH = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    hazard_tracker_if #(.REG_AW(4), .SEL_W(2), .CNT_W(16)) bus ();
    hazard_tracker_if #(.REG_AW(4), .SEL_W(2), .CNT_W(2))  bus2 ();

    assign bus2.id_valid  = bus.id_valid;
    assign bus2.id_rd     = bus.id_rd;
    assign bus2.id_rw     = bus.id_rw;
    assign bus2.id_load   = bus.id_load;
    assign bus2.id_rs     = bus.id_rs;
    assign bus2.id_rt     = bus.id_rt;
    assign bus2.id_use_rs = bus.id_use_rs;
    assign bus2.id_use_rt = bus.id_use_rt;
    assign bus2.id_jr     = bus.id_jr;
    assign bus2.hold      = bus.hold;
    assign bus2.flush     = bus.flush;

    hazard_tracker #(.REG_AW(4), .DEPTH(DEPTH), .CNT_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (bus)
    );

    hazard_tracker #(.REG_AW(4), .DEPTH(DEPTH), .CNT_W(2)) dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (bus2)
    );

    int total = 0;
    int bad = 0;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: newest-first list of what entered EX on each advancing edge.
    typedef struct {
        bit v;
        int rd;
        bit wr;
        bit ld;
    } ent_t;

    ent_t hist[$];
    int   m_fa = 0;
    int   m_fb = 0;
    int   m_cnt = 0;
    bit   started = 1'b0;

    function automatic int sel_for(input int r);
        for (int i = 0; i < DEPTH - 1 && i < hist.size(); i++) begin
            if (hist[i].v && hist[i].wr && hist[i].rd == r && r != 0)
                return i + 1;
        end
        return 0;
    endfunction

    function automatic bit load_in_ex(input int r);
        if (hist.size() == 0) return 1'b0;
        return hist[0].v && hist[0].wr && hist[0].ld &&
               hist[0].rd == r && r != 0;
    endfunction

    function automatic bit m_stall();
        bit h;
        h = (bus.id_use_rs && load_in_ex(int'(bus.id_rs))) ||
            (bus.id_use_rt && load_in_ex(int'(bus.id_rt))) ||
            (bus.id_jr && load_in_ex(int'(bus.id_rs)));
        return bus.id_valid && !bus.flush && h;
    endfunction

    always @(posedge clk) begin : model
        bit   st;
        bit   iss;
        ent_t e;
        if (!rst_n) begin
            hist.delete();
            m_fa = 0;
            m_fb = 0;
            m_cnt = 0;
            started = 1'b1;
        end else if (!bus.hold) begin
            st = m_stall();
            iss = bus.id_valid && !st && !bus.flush;
            e.v = iss;
            e.rd = int'(bus.id_rd);
            e.wr = bus.id_rw && bus.id_rd != 0;
            e.ld = bus.id_load;
            m_fa = iss ? sel_for(int'(bus.id_rs)) : 0;
            m_fb = iss ? sel_for(int'(bus.id_rt)) : 0;
            if (st) m_cnt++;
            hist.push_front(e);
            if (hist.size() > DEPTH) void'(hist.pop_back());
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("m_stall", int'(bus.stall), int'(m_stall()));
            chk("m_jr_sel", int'(bus.jr_sel),
                bus.id_jr ? sel_for(int'(bus.id_rs)) : 0);
            chk("m_fwd_a", int'(bus.fwd_a), m_fa);
            chk("m_fwd_b", int'(bus.fwd_b), m_fb);
            chk("m_count", int'(bus.stall_count),
                m_cnt > 65535 ? 65535 : m_cnt);
            chk("m_count2", int'(bus2.stall_count), m_cnt > 3 ? 3 : m_cnt);
        end
    end

    task automatic drv(input bit v, input int rd, input bit rw,
                       input bit ld, input int rs, input int rt,
                       input bit urs, input bit urt, input bit jr);
        bus.id_valid  = v;
        bus.id_rd     = 4'(rd);
        bus.id_rw     = rw;
        bus.id_load   = ld;
        bus.id_rs     = 4'(rs);
        bus.id_rt     = 4'(rt);
        bus.id_use_rs = urs;
        bus.id_use_rt = urt;
        bus.id_jr     = jr;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) tick();
    endtask

    initial begin
        bus.hold = 1'b0;
        bus.flush = 1'b0;
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        tick();
        chk("rst_fwd_a", int'(bus.fwd_a), 0);
        chk("rst_fwd_b", int'(bus.fwd_b), 0);
        chk("rst_stall", int'(bus.stall), 0);
        chk("rst_jr_sel", int'(bus.jr_sel), 0);
        chk("rst_count", int'(bus.stall_count), 0);
        rst_n = 1'b1;
        tick();

        // Distance 1, 2, 3 from an ALU write of r3.
        drv(1, 3, 1, 0, 0, 0, 0, 0, 0); tick();
        drv(1, 1, 1, 0, 3, 0, 1, 0, 0);
        chk("d1_stall", int'(bus.stall), 0);
        tick();
        chk("d1_fwd_a", int'(bus.fwd_a), 1);
        drain();
        drv(1, 3, 1, 0, 0, 0, 0, 0, 0); tick();
        drv(1, 7, 1, 0, 0, 0, 0, 0, 0); tick();
        drv(1, 1, 1, 0, 3, 0, 1, 0, 0); tick();
        chk("d2_fwd_a", int'(bus.fwd_a), 2);
        drain();
        drv(1, 3, 1, 0, 0, 0, 0, 0, 0); tick();
        drv(1, 7, 1, 0, 0, 0, 0, 0, 0); tick();
        drv(1, 7, 1, 0, 0, 0, 0, 0, 0); tick();
        drv(1, 1, 1, 0, 3, 0, 1, 0, 0); tick();
        chk("d3_fwd_a", int'(bus.fwd_a), 0);
        drain();

        // Two writers of r4: youngest wins.
        drv(1, 4, 1, 0, 0, 0, 0, 0, 0); tick();
        drv(1, 4, 1, 0, 0, 0, 0, 0, 0); tick();
        drv(1, 2, 1, 0, 0, 4, 0, 1, 0); tick();
        chk("young_fwd_b", int'(bus.fwd_b), 1);
        drain();

        // Load-use on rt.
        drv(1, 5, 1, 1, 0, 0, 0, 0, 0); tick();
        drv(1, 2, 1, 0, 0, 5, 0, 1, 0);
        chk("lu_stall", int'(bus.stall), 1);
        tick();
        chk("lu_count", int'(bus.stall_count), 1);
        chk("lu_bubble_fwd_b", int'(bus.fwd_b), 0);
        chk("lu_stall_gone", int'(bus.stall), 0);
        tick();
        chk("lu_fwd_b", int'(bus.fwd_b), 2);
        drain();

        // r0 writes and non-writing instructions never forward.
        drv(1, 0, 1, 0, 0, 0, 0, 0, 0); tick();
        drv(1, 9, 0, 0, 0, 0, 0, 0, 0); tick();
        drv(1, 0, 1, 1, 0, 0, 0, 0, 0); tick();
        drv(1, 2, 1, 0, 0, 9, 1, 1, 0);
        chk("r0_stall", int'(bus.stall), 0);
        tick();
        chk("r0_fwd_a", int'(bus.fwd_a), 0);
        chk("nowr_fwd_b", int'(bus.fwd_b), 0);
        drain();

        // JR after ALU write, then after load.
        drv(1, 6, 1, 0, 0, 0, 0, 0, 0); tick();
        drv(1, 0, 0, 0, 6, 0, 0, 0, 1);
        chk("jr_alu_sel", int'(bus.jr_sel), 1);
        chk("jr_alu_stall", int'(bus.stall), 0);
        tick();
        drain();
        drv(1, 6, 1, 1, 0, 0, 0, 0, 0); tick();
        drv(1, 0, 0, 0, 6, 0, 0, 0, 1);
        chk("jr_ld_stall", int'(bus.stall), 1);
        tick();
        chk("jr_ld_stall_gone", int'(bus.stall), 0);
        chk("jr_ld_sel", int'(bus.jr_sel), 2);
        tick();
        drain();

        // Hold for three cycles mid-dependency.
        drv(1, 9, 1, 0, 0, 0, 0, 0, 0); tick();
        drv(1, 1, 1, 0, 9, 0, 1, 0, 0); tick();
        chk("hold_pre_fwd_a", int'(bus.fwd_a), 1);
        drv(1, 2, 1, 0, 9, 0, 1, 0, 0);
        bus.hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hold_fwd_a", int'(bus.fwd_a), 1);
        end
        bus.hold = 1'b0;
        tick();
        chk("hold_post_fwd_a", int'(bus.fwd_a), 2);
        drain();

        // Flush beats a load-use hazard.
        drv(1, 10, 1, 1, 0, 0, 0, 0, 0); tick();
        bus.flush = 1'b1;
        drv(1, 2, 1, 0, 0, 10, 0, 1, 0);
        chk("flush_stall", int'(bus.stall), 0);
        tick();
        bus.flush = 1'b0;
        chk("flush_bubble_fwd_b", int'(bus.fwd_b), 0);
        chk("flush_count", int'(bus.stall_count), 2);
        drv(1, 2, 1, 0, 0, 10, 0, 1, 0);
        chk("flush_next_stall", int'(bus.stall), 0);
        tick();
        chk("flush_next_fwd_b", int'(bus.fwd_b), 2);
        drain();

        // Three more load-use stalls: 5 total, narrow counter saturates.
        for (int i = 0; i < 3; i++) begin
            drv(1, 12, 1, 1, 0, 0, 0, 0, 0); tick();
            drv(1, 2, 1, 0, 12, 0, 1, 0, 0); tick();
            tick();
        end
        chk("sat_count", int'(bus.stall_count), 5);
        chk("sat_count2", int'(bus2.stall_count), 3);
        drain();

        // Reset in the middle of a stall.
        drv(1, 11, 1, 1, 0, 0, 0, 0, 0); tick();
        drv(1, 2, 1, 0, 11, 0, 1, 0, 0);
        chk("rst_mid_stall_pre", int'(bus.stall), 1);
        rst_n = 1'b0;
        tick();
        chk("rst_mid_stall", int'(bus.stall), 0);
        chk("rst_mid_fwd_a", int'(bus.fwd_a), 0);
        chk("rst_mid_fwd_b", int'(bus.fwd_b), 0);
        chk("rst_mid_jr_sel", int'(bus.jr_sel), 0);
        chk("rst_mid_count", int'(bus.stall_count), 0);
        chk("rst_mid_count2", int'(bus2.stall_count), 0);
        rst_n = 1'b1;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
